// File: rtl/core_pkg.sv
// Shared pipeline definitions: stage indices, scoreboard entry layout and
// the hazard-cause encoding used by the pipeline-control logic.
package core_pkg;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  // Wide enough for any supported register-address width; narrower
  // addresses are zero-extended into it.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
    logic               wr;
  } sb_entry_t;

  typedef enum logic [1:0] {
    NONE,
    LOAD_USE,
    EX_BUSY,
    REDIRECT
  } hazard_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: per-stage valid bits, destination scoreboard, and the
// stall/bubble/flush controls for every pipeline register plus perf counters.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int BR_STAGE   = 3,
  parameter int LOAD_LAT   = 1,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  redirect,
  input  logic                  ex_busy,
  output logic                  pc_en,
  output logic [NUM_STAGES-2:0] pipe_en,
  output logic [NUM_STAGES-2:0] pipe_bubble,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  ex_kill,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int NSB = NUM_STAGES - ST_EX;

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  sb_entry_t             sb_q [NSB];
  sb_entry_t             sb_d [NSB];
  logic                  load_use, busy_v, redirect_v;
  logic                  stall_inc, flush_inc;
  hazard_e               cause;

  function automatic logic src_hit(logic uses, logic [REG_ADDR_W-1:0] src, sb_entry_t e);
    return uses && (src != '0) && e.valid && e.is_load && e.wr && (e.rd == SB_RD_W'(src));
  endfunction

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (src_hit(id_uses_rs1, id_rs1, sb_q[k]) || src_hit(id_uses_rs2, id_rs2, sb_q[k])) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use && valid_q[ST_ID];
  end

  assign busy_v     = ex_busy && valid_q[ST_EX];
  assign redirect_v = redirect && valid_q[BR_STAGE];

  always_comb begin
    cause = NONE;
    if (!rst && enable) begin
      if (redirect_v)    cause = REDIRECT;
      else if (busy_v)   cause = EX_BUSY;
      else if (load_use) cause = LOAD_USE;
    end
  end

  // A pipeline register loads a bubble whenever pipe_bubble is set, even if
  // its pipe_en is low; this is how a held EX still drains a bubble into MEM.
  always_comb begin
    pc_en       = 1'b1;
    pipe_en     = '1;
    pipe_bubble = '0;
    ex_kill     = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      pipe_en     = '0;
      pipe_bubble = '1;
    end else if (!enable) begin
      pc_en   = 1'b0;
      pipe_en = '0;
    end else begin
      case (cause)
        REDIRECT: begin
          for (int i = 0; i < BR_STAGE; i++) pipe_bubble[i] = 1'b1;
          ex_kill = (BR_STAGE > ST_EX) && valid_q[ST_EX];
        end
        EX_BUSY: begin
          pc_en              = 1'b0;
          pipe_en[ST_EX:0]   = '0;
          pipe_bubble[ST_EX] = 1'b1;
        end
        LOAD_USE: begin
          pc_en              = 1'b0;
          pipe_en[ST_IF]     = 1'b0;
          pipe_bubble[ST_ID] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    sb_d    = sb_q;
    if (pc_en) valid_d[ST_IF] = 1'b1;
    for (int i = 0; i < NUM_STAGES-1; i++) begin
      if (pipe_en[i] || pipe_bubble[i]) valid_d[i+1] = valid_q[i] && !pipe_bubble[i];
    end
    if (pipe_en[ST_ID] || pipe_bubble[ST_ID]) begin
      sb_d[0] = '0;
      if (!pipe_bubble[ST_ID]) begin
        sb_d[0].valid   = valid_q[ST_ID];
        sb_d[0].rd      = SB_RD_W'(id_rd);
        sb_d[0].is_load = id_mem_read;
        sb_d[0].wr      = id_reg_write;
      end
    end
    for (int k = 1; k < NSB; k++) begin
      if (pipe_en[ST_EX+k-1] || pipe_bubble[ST_EX+k-1]) begin
        sb_d[k] = pipe_bubble[ST_EX+k-1] ? '0 : sb_q[k-1];
      end
    end
  end

  // NOTE: the scoreboard array is reset, not left to fill, because stale
  // entries would raise false load-use stalls right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < NSB; k++) sb_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      sb_q    <= sb_d;
    end
  end

  assign stage_valid = rst ? '0 : valid_q;
  assign stall_inc   = (cause == EX_BUSY) || (cause == LOAD_USE);
  assign flush_inc   = (cause == REDIRECT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: default 5-stage instance plus a
// 6-stage, LOAD_LAT=2, 3-bit-counter instance for stall length and saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, redirect, ex_busy;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        pc_en, ex_kill;
  logic [3:0]  pipe_en, pipe_bubble;
  logic [4:0]  stage_valid;
  logic [31:0] stall_cnt, flush_cnt;

  logic        rst6, enable6, uses1_6, uses2_6, reg_write6, mem_read6, redirect6, ex_busy6;
  logic [4:0]  rs1_6, rs2_6, rd6;
  logic        pc_en6, ex_kill6;
  logic [4:0]  pipe_en6, pipe_bubble6;
  logic [5:0]  stage_valid6;
  logic [2:0]  stall_cnt6, flush_cnt6;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .redirect(redirect), .ex_busy(ex_busy),
    .pc_en(pc_en), .pipe_en(pipe_en), .pipe_bubble(pipe_bubble), .stage_valid(stage_valid),
    .ex_kill(ex_kill), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(6), .BR_STAGE(3), .LOAD_LAT(2), .REG_ADDR_W(5), .CNT_W(3)) dut6 (
    .clk(clk), .rst(rst6), .enable(enable6),
    .id_rs1(rs1_6), .id_rs2(rs2_6), .id_uses_rs1(uses1_6), .id_uses_rs2(uses2_6),
    .id_rd(rd6), .id_reg_write(reg_write6), .id_mem_read(mem_read6),
    .redirect(redirect6), .ex_busy(ex_busy6),
    .pc_en(pc_en6), .pipe_en(pipe_en6), .pipe_bubble(pipe_bubble6), .stage_valid(stage_valid6),
    .ex_kill(ex_kill6), .stall_cnt(stall_cnt6), .flush_cnt(flush_cnt6)
  );

  typedef struct packed {
    logic en; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic wr; logic mr; logic redir; logic busy;
  } in_t;

  typedef struct packed {
    logic pc; logic [3:0] pe; logic [3:0] pb; logic [4:0] sv; logic kill;
    logic [31:0] sc; logic [31:0] fc;
  } obs_t;

  typedef struct packed {
    logic pc; logic [4:0] pe; logic [4:0] pb; logic [2:0] sc;
  } obs6_t;

  obs_t  exp_q[$];
  obs6_t exp6_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic in_t i_idle(input logic en = 1'b1);
    in_t s;
    s = '0;
    s.en = en;
    return s;
  endfunction

  function automatic in_t i_load(input logic [4:0] rd);
    in_t s;
    s = i_idle();
    s.rd = rd; s.wr = 1'b1; s.mr = 1'b1;
    return s;
  endfunction

  function automatic in_t i_use(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    in_t s;
    s = i_idle();
    s.rs1 = r1; s.u1 = u1; s.rs2 = r2; s.u2 = u2; s.rd = 5'd6; s.wr = 1'b1;
    return s;
  endfunction

  function automatic obs_t e_mk(logic pc, logic [3:0] pe, logic [3:0] pb, logic [4:0] sv,
                                logic kill, int sc, int fc);
    obs_t o;
    o.pc = pc; o.pe = pe; o.pb = pb; o.sv = sv; o.kill = kill; o.sc = 32'(sc); o.fc = 32'(fc);
    return o;
  endfunction

  function automatic obs_t e_go(logic [4:0] sv, int sc, int fc);    return e_mk(1'b1, 4'hF, 4'h0, sv, 1'b0, sc, fc); endfunction
  function automatic obs_t e_lu(logic [4:0] sv, int sc, int fc);    return e_mk(1'b0, 4'b1110, 4'b0010, sv, 1'b0, sc, fc); endfunction
  function automatic obs_t e_busy(logic [4:0] sv, int sc, int fc);  return e_mk(1'b0, 4'b1000, 4'b0100, sv, 1'b0, sc, fc); endfunction
  function automatic obs_t e_flush(logic [4:0] sv, int sc, int fc); return e_mk(1'b1, 4'hF, 4'b0111, sv, 1'b1, sc, fc); endfunction
  function automatic obs_t e_frz(logic [4:0] sv, int sc, int fc);   return e_mk(1'b0, 4'h0, 4'h0, sv, 1'b0, sc, fc); endfunction

  function automatic obs6_t e6(logic pc, logic [4:0] pe, logic [4:0] pb, int sc);
    obs6_t o;
    o.pc = pc; o.pe = pe; o.pb = pb; o.sc = 3'(sc);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pc_en=%b pipe_en=%b bubble=%b valid=%b kill=%b stall=%0d flush=%0d",
                     o.pc, o.pe, o.pb, o.sv, o.kill, o.sc, o.fc);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc = pc_en; o.pe = pipe_en; o.pb = pipe_bubble; o.sv = stage_valid;
    o.kill = ex_kill; o.sc = stall_cnt; o.fc = flush_cnt;
    return o;
  endfunction

  function automatic obs6_t sample6();
    obs6_t o;
    o.pc = pc_en6; o.pe = pipe_en6; o.pb = pipe_bubble6; o.sc = stall_cnt6;
    return o;
  endfunction

  task automatic drive(input in_t s);
    enable = s.en; id_rs1 = s.rs1; id_uses_rs1 = s.u1; id_rs2 = s.rs2; id_uses_rs2 = s.u2;
    id_rd = s.rd; id_reg_write = s.wr; id_mem_read = s.mr; redirect = s.redir; ex_busy = s.busy;
  endtask

  task automatic drive6(input in_t s);
    enable6 = s.en; rs1_6 = s.rs1; uses1_6 = s.u1; rs2_6 = s.rs2; uses2_6 = s.u2;
    rd6 = s.rd; reg_write6 = s.wr; mem_read6 = s.mr; redirect6 = s.redir; ex_busy6 = s.busy;
  endtask

  task automatic test_reset();
    in_t stim[$]; obs_t want[$]; obs_t got, exp;
    for (int k = 0; k < 3; k++) begin
      stim.push_back(i_idle(1'b0));
      want.push_back(e_mk(1'b0, 4'h0, 4'hF, 5'h00, 1'b0, 0, 0));
    end
    foreach (stim[k]) begin
      @(negedge clk); drive(stim[k]); exp_q.push_back(want[k]);
      #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset[%0d]: got %s | want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_fill();
    in_t stim[$]; obs_t want[$]; obs_t got, exp;
    logic [4:0] fill [6];
    fill = '{5'h00, 5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F};
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      stim.push_back(i_idle());
      want.push_back(e_go(fill[k], 0, 0));
    end
    foreach (stim[k]) begin
      @(negedge clk); drive(stim[k]); exp_q.push_back(want[k]);
      #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL fill[%0d]: got %s | want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_load_use();
    in_t stim[$]; obs_t want[$]; obs_t got, exp;
    stim.push_back(i_load(5'd5));               want.push_back(e_go(5'h1F, 0, 0));
    stim.push_back(i_use(5'd5, 1'b1, 5'd0, 1'b0)); want.push_back(e_lu(5'h1F, 0, 0));
    stim.push_back(i_use(5'd5, 1'b1, 5'd0, 1'b0)); want.push_back(e_go(5'b11011, 1, 0));
    stim.push_back(i_idle());                   want.push_back(e_go(5'b10111, 1, 0));
    stim.push_back(i_idle());                   want.push_back(e_go(5'b01111, 1, 0));
    stim.push_back(i_idle());                   want.push_back(e_go(5'h1F, 1, 0));
    stim.push_back(i_load(5'd9));               want.push_back(e_go(5'h1F, 1, 0));
    stim.push_back(i_use(5'd0, 1'b0, 5'd9, 1'b1)); want.push_back(e_lu(5'h1F, 1, 0));
    stim.push_back(i_use(5'd0, 1'b0, 5'd9, 1'b1)); want.push_back(e_go(5'b11011, 2, 0));
    stim.push_back(i_idle());                   want.push_back(e_go(5'b10111, 2, 0));
    stim.push_back(i_idle());                   want.push_back(e_go(5'b01111, 2, 0));
    stim.push_back(i_idle());                   want.push_back(e_go(5'h1F, 2, 0));
    foreach (stim[k]) begin
      @(negedge clk); drive(stim[k]); exp_q.push_back(want[k]);
      #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %s | want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_no_stall();
    in_t stim[$]; obs_t want[$]; obs_t got, exp;
    stim.push_back(i_load(5'd0));                  want.push_back(e_go(5'h1F, 2, 0));
    stim.push_back(i_use(5'd0, 1'b1, 5'd0, 1'b1)); want.push_back(e_go(5'h1F, 2, 0));
    stim.push_back(i_load(5'd5));                  want.push_back(e_go(5'h1F, 2, 0));
    stim.push_back(i_use(5'd5, 1'b0, 5'd5, 1'b0)); want.push_back(e_go(5'h1F, 2, 0));
    stim.push_back(i_use(5'd5, 1'b1, 5'd0, 1'b0)); want.push_back(e_go(5'h1F, 2, 0));
    foreach (stim[k]) begin
      @(negedge clk); drive(stim[k]); exp_q.push_back(want[k]);
      #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL no_stall[%0d]: got %s | want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_redirect();
    in_t stim[$]; obs_t want[$]; obs_t got, exp; in_t s;
    stim.push_back(i_load(5'd7)); want.push_back(e_go(5'h1F, 2, 0));
    s = i_use(5'd7, 1'b1, 5'd0, 1'b0); s.redir = 1'b1; s.busy = 1'b1;
    stim.push_back(s);            want.push_back(e_flush(5'h1F, 2, 0));
    stim.push_back(i_idle());     want.push_back(e_go(5'b10001, 2, 1));
    s = i_idle(); s.redir = 1'b1;
    stim.push_back(s);            want.push_back(e_go(5'b00011, 2, 1));
    stim.push_back(i_idle());     want.push_back(e_go(5'b00111, 2, 1));
    stim.push_back(i_idle());     want.push_back(e_go(5'b01111, 2, 1));
    stim.push_back(i_idle());     want.push_back(e_go(5'h1F, 2, 1));
    foreach (stim[k]) begin
      @(negedge clk); drive(stim[k]); exp_q.push_back(want[k]);
      #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL redirect[%0d]: got %s | want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_ex_busy();
    in_t stim[$]; obs_t want[$]; obs_t got, exp; in_t b, bf;
    b = i_idle(); b.busy = 1'b1;
    bf = b; bf.en = 1'b0;
    stim.push_back(b);        want.push_back(e_busy(5'h1F, 2, 1));
    stim.push_back(b);        want.push_back(e_busy(5'b10111, 3, 1));
    stim.push_back(bf);       want.push_back(e_frz(5'b00111, 4, 1));
    stim.push_back(bf);       want.push_back(e_frz(5'b00111, 4, 1));
    stim.push_back(b);        want.push_back(e_busy(5'b00111, 4, 1));
    stim.push_back(b);        want.push_back(e_busy(5'b00111, 5, 1));
    stim.push_back(i_idle()); want.push_back(e_go(5'b00111, 6, 1));
    stim.push_back(i_idle()); want.push_back(e_go(5'b01111, 6, 1));
    stim.push_back(i_idle()); want.push_back(e_go(5'h1F, 6, 1));
    foreach (stim[k]) begin
      @(negedge clk); drive(stim[k]); exp_q.push_back(want[k]);
      #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ex_busy[%0d]: got %s | want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs6_t got, exp; logic [5:0] sv_exp; logic stall; int sc; in_t s;
    sc = 0;
    rst6 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); drive6(i_idle()); exp6_q.push_back(e6(1'b1, 5'h1F, 5'h00, 0));
      #1; got = sample6(); exp = exp6_q.pop_front(); sv_exp = 6'((1 << k) - 1);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL lat2_fill[%0d]: got %h want %h", k, got, exp);
      end
      n_vec++;
      if (stage_valid6 !== sv_exp) begin
        n_err++;
        $display("FAIL lat2_valid[%0d]: got %b want %b", k, stage_valid6, sv_exp);
      end
    end
    for (int ep = 0; ep < 5; ep++) begin
      for (int st = 0; st < 4; st++) begin
        s = (st == 0) ? i_load(5'd5) : i_use(5'd5, 1'b1, 5'd0, 1'b0);
        stall = (st == 1) || (st == 2);
        @(negedge clk); drive6(s);
        exp6_q.push_back(e6(!stall, stall ? 5'b11110 : 5'h1F, stall ? 5'b00010 : 5'h00, sc));
        #1; got = sample6(); exp = exp6_q.pop_front(); n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL lat2_ep%0d[%0d]: got pc=%b pe=%b pb=%b stall=%0d want pc=%b pe=%b pb=%b stall=%0d",
                   ep, st, got.pc, got.pe, got.pb, got.sc, exp.pc, exp.pe, exp.pb, exp.sc);
        end
        if (stall && sc < 7) sc++;
      end
    end
    @(negedge clk); drive6(i_idle()); exp6_q.push_back(e6(1'b1, 5'h1F, 5'h00, 7));
    #1; got = sample6(); exp = exp6_q.pop_front(); n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL lat2_saturate: got stall=%0d want stall=%0d", got.sc, exp.sc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;  drive(i_idle(1'b0));
    rst6 = 1'b1; drive6(i_idle(1'b0));
    test_reset();
    test_fill();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_ex_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline-control block for the next-generation in-order RV64 core.
- Owns the per-stage valid bits and a destination-register scoreboard.
- Generates register-enable, bubble and flush controls for every pipeline register, which the 5-stage design currently lacks:
  - load-use stall
  - multi-cycle EX stall
  - taken branch/jump flush
- Parametrised in stage count, branch-resolve stage and load latency; also keeps saturating stall/flush performance counters.

Parameters:
NUM_STAGES, 5, pipeline depth; stage 0=IF, 1=ID, 2=EX, ..., NUM_STAGES-1=WB; legal range 4..8
BR_STAGE, 3, stage in which branch/jump redirect is resolved; legal range 2..NUM_STAGES-2
LOAD_LAT, 1, number of stages after ID (starting at EX) in which a load result cannot yet be forwarded; legal range 1..NUM_STAGES-3
REG_ADDR_W, 5, register-address width
CNT_W, 32, performance-counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  global run enable; 0 freezes all state
id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_ADDR_W  rd of the instruction in ID
id_reg_write  in  1  ID instruction writes rd
id_mem_read  in  1  ID instruction is a load
redirect  in  1  taken branch/jump resolved in BR_STAGE, qualified by stage_valid[BR_STAGE]
ex_busy  in  1  multi-cycle EX unit not done
pc_en  out  1  PC register enable
pipe_en  out  NUM_STAGES-1  bit i: enable of the register between stage i and i+1
pipe_bubble  out  NUM_STAGES-1  bit i: that register loads a bubble (control zeroed) instead of stage i data
stage_valid  out  NUM_STAGES  bit i: stage i holds a valid instruction (bit 0 is always 1 outside reset)
ex_kill  out  1  abort the multi-cycle EX operation
stall_cnt  out  CNT_W  cycles with pc_en=0 caused by a stall
flush_cnt  out  CNT_W  redirect events accepted

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - the valid bits
  - the scoreboard
  - both counters
- While rst=1, outputs are: pc_en=0, pipe_en=0, pipe_bubble=all 1, ex_kill=0, stage_valid=0.
- Scoreboard:
  - Holds one entry {valid, rd, is_load, wr} per stage from EX to NUM_STAGES-1.
  - Entries advance with pipe_en; an entry is cleared when its stage is bubbled.
- Hazard evaluation is combinational in the current cycle. Priority: redirect > ex_busy > load-use.
- Load-use hazard:
  - Asserted when the ID instruction is valid and reads a source s, where s is id_rs1 with id_uses_rs1 or id_rs2 with id_uses_rs2.
  - s must be nonzero, and s must equal rd of a valid load entry in stages EX..EX+LOAD_LAT-1.
  - Register x0 never creates a hazard.
- Load-use response:
  - pc_en=0; pipe_en[0]=0 (IF/ID held).
  - pipe_en[1]=1 with pipe_bubble[1]=1.
  - Older stages advance.
  - stall_cnt increments.
- ex_busy response (EX valid):
  - pc_en=0; pipe_en[0..2]=0.
  - Register after EX loads a bubble.
  - Older stages advance.
  - stall_cnt increments.
- Redirect response:
  - pc_en=1 (PC loads the target).
  - Every register feeding stages 1..BR_STAGE loads a bubble.
  - The BR_STAGE instruction and older ones advance normally.
  - ex_kill=1 if BR_STAGE>2 and EX is valid.
  - flush_cnt increments.
  - Any simultaneous ex_busy or load-use is ignored, because those instructions are younger and flushed.
- No hazard: all enables=1, no bubbles.
- Back-to-back stalls: hold for as long as the condition persists. A load-use stall resolves after LOAD_LAT cycles at most.
- enable=0:
  - All outputs behave as stall (pc_en=0, pipe_en=0).
  - Counters and state hold; no counting.
- Counters saturate at 2^CNT_W-1.
- Stage 0 valid only after the first post-reset cycle with pc_en=1; younger-stage valid bits follow the fetch stream.

Decomposition:
- Shared package core_pkg:
  - stage-index constants (ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB)
  - scoreboard-entry struct
  - hazard-cause enum {NONE, LOAD_USE, EX_BUSY, REDIRECT}
- One sub-module: sat_counter (CNT_W, increment enable, synchronous reset), instantiated twice.

Test Plan:
1. Reset held 3 cycles, then enable=1 with no hazards -> pc_en=1, pipe_en=all 1, stage_valid fills 1 bit per cycle to 5'b11111 after 5 cycles, counters 0.
2. Load x5 in ID, then next instruction reads rs1=x5 (LOAD_LAT=1) -> exactly 1 cycle with pc_en=0, pipe_en[0]=0, pipe_bubble[1]=1; stall_cnt=1.
3. Load x0 followed by a reader of x0; and a load x5 followed by id_uses_rs2=0, rs2=5 -> no stall in either case.
4. redirect=1 with BR_STAGE=3 and EX busy plus load-use pending -> pipe_bubble[0..2]=1, ex_kill=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
5. ex_busy for 4 cycles -> pc_en=0, pipe_en[2:0]=0 for 4 cycles, bubble into MEM each cycle, stall_cnt=4; enable=0 mid-stall freezes stall_cnt.
6. NUM_STAGES=6, LOAD_LAT=2, CNT_W=3 -> load-use stall of 2 cycles; 9 stalls leave stall_cnt=7 (saturated).
